dmem_ip_responder: RTL
======================

// Module: dmem_ip_responder
// PURPOSE
//  MEM-stage responder for decoded MemRW {DRW[1:0],DREQ}. Services four ops:
//  write DI1 (DRW=00), read DOUT1 (10) against internal data RAM, and
//  write DI2 (01), read DOUT2 (11) against the custom-IP port via req/ack.
//  Drives BUSY to stall the pipeline and pulses DVALID with read data.
// PARAMETERS
//  AW          10   word-address width; internal RAM depth = 2**AW words
//  DW          32   data width
//  MEM_LAT     2    RAM read latency in cycles, legal 1..15
//  IP_TIMEOUT  255  max cycles IP_REQ waits for IP_ACK (DMEM_IP_TIMEOUT_EN only)
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RSTN      in   1   synchronous active-low reset
//  DREQ      in   1   memory access request (MemRW bit0)
//  DRW       in   2   op select (MemRW bits[2:1]), see BEHAVIOUR
//  ADDR      in   AW  word address
//  DI        in   DW  store data
//  BUSY      out  1   stall request to pipeline (combinational)
//  DVALID    out  1   one-cycle pulse: DOUT holds read result
//  DOUT      out  DW  read data (DOUT1 or DOUT2)
//  IP_REQ    out  1   IP request, held until IP_ACK
//  IP_WE     out  1   1=IP write (DI2), 0=IP read (DOUT2)
//  IP_ADDR   out  AW  captured address
//  IP_WDATA  out  DW  captured store data
//  IP_ACK    in   1   IP completion; sampled only while IP_REQ=1
//  IP_RDATA  in   DW  IP read data, valid with IP_ACK
//  ERR       out  1   one-cycle pulse on IP timeout
// BEHAVIOUR
//  - States: IDLE, RD_WAIT, IP_WAIT, DONE. Reset: IDLE; BUSY, DVALID, IP_REQ,
//    IP_WE, ERR = 0; DOUT, IP_ADDR, IP_WDATA = 0. RAM contents not cleared.
//  - Accept only in IDLE when DREQ=1 (cycle T); capture DRW, ADDR, DI.
//  - BUSY = (state==RD_WAIT|IP_WAIT) | (state==IDLE & DREQ & DRW!=00).
//    BUSY=0 in DONE so pipeline advances; request seen in DONE is never accepted.
//  - DRW=00: RAM[ADDR]<=DI at end of T; no BUSY, no DVALID; stay IDLE.
//    Back-to-back writes every cycle; read at T+1 of same ADDR returns new data.
//  - DRW=10: RD_WAIT with counter=MEM_LAT; BUSY high T..T+MEM_LAT;
//    DONE at T+MEM_LAT+1 with DVALID=1, DOUT=RAM[ADDR captured at T].
//  - DRW=01/11: IP_WAIT; IP_REQ=1, IP_WE=~DRW[1], IP_ADDR/IP_WDATA valid from
//    T+1; held stable until IP_ACK sampled high (cycle A, inclusive);
//    IP_REQ=0 and DONE at A+1; DVALID=1 at A+1; DOUT=IP_RDATA (11) or
//    unchanged (01). DVALID pulses for writes too (completion).
//  - DOUT holds last value outside DVALID. IP_ACK while IP_REQ=0 ignored.
//  - DONE -> IDLE unconditionally after one cycle.
//  - RSTN low at any edge, any state: IDLE next cycle, IP_REQ drops, no
//    DVALID/ERR for the aborted op.
// CONFIGURATION
//  DMEM_IP_TIMEOUT_EN defined: 8-bit wait counter in IP_WAIT; IP_TIMEOUT
//    cycles of IP_REQ without IP_ACK -> IP_REQ drops, ERR and DVALID pulse
//    next cycle, DOUT=0 for reads, then IDLE. IP_ACK on the timeout cycle
//    wins (normal completion, no ERR).
//  Not defined: IP_WAIT waits indefinitely; ERR tied 0; no counter logic.
// TESTING
//  - Reset: RSTN=0 2 cycles -> all outputs 0, state IDLE, BUSY=0 with DREQ=0.
//  - Write 0xDEADBEEF @0x005 (DRW=00), next cycle read @0x005 (DRW=10),
//    MEM_LAT=2 -> BUSY high 3 cycles, DVALID 4th cycle, DOUT=0xDEADBEEF.
//  - IP read DRW=11 @0x010, IP_ACK after 5 cycles with IP_RDATA=0x1234 ->
//    IP_REQ high 5 cycles, DVALID next cycle, DOUT=0x00001234, IP_WE=0.
//  - IP write DRW=01 DI=0xA5A5A5A5, IP_ACK same cycle IP_REQ rises ->
//    IP_WE=1, IP_WDATA=0xA5A5A5A5, one-cycle IP_REQ, DVALID next cycle.
//  - With DMEM_IP_TIMEOUT_EN, IP_TIMEOUT=8, no IP_ACK -> IP_REQ 8 cycles,
//    then ERR=1, DVALID=1, DOUT=0; without macro BUSY stays high.
//  - RSTN=0 during IP_WAIT -> IP_REQ=0 next cycle, no DVALID, next op accepted.

Source files
------------

// File: rtl/dmem_ip_responder.sv
// MEM-stage responder: RAM writes/reads and custom-IP req/ack accesses with pipeline stall.
// Define DMEM_IP_TIMEOUT_EN to abort IP accesses that see no IP_ACK within IP_TIMEOUT cycles.
//
// state   | meaning
// IDLE    | accepts DREQ; RAM writes complete here
// RD_WAIT | RAM read latency countdown
// IP_WAIT | IP_REQ held until IP_ACK (or timeout)
// DONE    | DVALID/ERR pulse, pipeline released
module dmem_ip_responder #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int IP_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DREQ,
  input  logic [1:0]    DRW,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DI,
  output logic          BUSY,
  output logic          DVALID,
  output logic [DW-1:0] DOUT,
  output logic          IP_REQ,
  output logic          IP_WE,
  output logic [AW-1:0] IP_ADDR,
  output logic [DW-1:0] IP_WDATA,
  input  logic          IP_ACK,
  input  logic [DW-1:0] IP_RDATA,
  output logic          ERR
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, IP_WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [3:0]    lat_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] dout_q;
  logic          we_q, dvalid_q, err_q;
  logic          accept, ram_wr, rd_acc, ip_acc, rd_last, ip_done, ip_tmo;

  assign accept  = (state == IDLE) && DREQ;
  assign ram_wr  = accept && (DRW == 2'b00);
  assign rd_acc  = accept && (DRW == 2'b10);
  assign ip_acc  = accept && DRW[0];
  assign rd_last = (state == RD_WAIT) && (lat_cnt == 4'd1);
  assign ip_done = (state == IP_WAIT) && IP_ACK;

`ifdef DMEM_IP_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Loaded on accept; reaching 1 without IP_ACK is the last allowed request cycle.
  assign ip_tmo = (state == IP_WAIT) && !IP_ACK && (wait_cnt == 8'd1);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wait_cnt <= '0;
    end else if (ip_acc) begin
      wait_cnt <= 8'(IP_TIMEOUT);
    end else if (state == IP_WAIT) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end
`else
  logic [31:0] unused_ip_timeout;
  assign unused_ip_timeout = 32'(IP_TIMEOUT);
  assign ip_tmo = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    IP_REQ   = 1'b0;
    case (state)
      IDLE: begin
        BUSY = DREQ && (DRW != 2'b00);
        if (rd_acc) begin
          state_nx = RD_WAIT;
        end else if (ip_acc) begin
          state_nx = IP_WAIT;
        end
      end
      RD_WAIT: begin
        BUSY = 1'b1;
        if (rd_last) state_nx = DONE;
      end
      IP_WAIT: begin
        BUSY   = 1'b1;
        IP_REQ = 1'b1;
        if (ip_done || ip_tmo) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      lat_cnt  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (accept) begin
        addr_q  <= ADDR;
        wdata_q <= DI;
      end
      if (ip_acc) we_q <= ~DRW[1];
      if (rd_acc) begin
        lat_cnt <= 4'(MEM_LAT);
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (rd_last) begin
        dvalid_q <= 1'b1;
        dout_q   <= mem[addr_q];
      end
      if (ip_done) begin
        dvalid_q <= 1'b1;
        if (!we_q) dout_q <= IP_RDATA;
      end else if (ip_tmo) begin
        dvalid_q <= 1'b1;
        err_q    <= 1'b1;
        if (!we_q) dout_q <= '0;
      end
    end
  end

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge CLK) begin
    if (RSTN && ram_wr) mem[ADDR] <= DI;
  end

  assign DVALID   = dvalid_q;
  assign DOUT     = dout_q;
  assign ERR      = err_q;
  assign IP_WE    = we_q;
  assign IP_ADDR  = addr_q;
  assign IP_WDATA = wdata_q;

endmodule
